// File: rtl/parallel_to_serial.sv
// parallel_to_serial: 48-bit CMD frame serializer, bit 47 first.
// Define CRC7_GEN_EN to generate CRC7 on the line and force the end bit.
module parallel_to_serial (
  input  logic        CLK,
  input  logic        RESET_L,
  input  logic        start_sending,
  input  logic [47:0] parallel_in,
  output logic        serial_out,
  output logic        cmd_oe,
  output logic        busy,
  output logic        finished
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [47:0] shreg;
  logic [47:0] shreg_n;
  logic [5:0]  cnt;
  logic [5:0]  cnt_n;
  logic        ser_n;
  logic        oe_n;
  logic        busy_n;
  logic        fin_n;
  logic        nxt_bit;

`ifdef CRC7_GEN_EN
  logic [6:0] crc;
  logic [6:0] crc_n;

  function automatic logic [6:0] crc_step(
    input logic [6:0] c,
    input logic       b
  );
    logic fb;
    fb = b ^ c[6];
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction
`endif

  // cnt is the index of the frame bit currently on the line
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    ser_n   = 1'b1;
    oe_n    = 1'b0;
    busy_n  = 1'b0;
    fin_n   = 1'b0;
    nxt_bit = shreg[47];
`ifdef CRC7_GEN_EN
    crc_n   = crc;
`endif
    unique case (state)
      IDLE: begin
        if (start_sending) begin
          state_n = SEND;
          shreg_n = {parallel_in[46:0], 1'b0};
          cnt_n   = 6'd47;
          ser_n   = parallel_in[47];
          oe_n    = 1'b1;
          busy_n  = 1'b1;
`ifdef CRC7_GEN_EN
          crc_n   = crc_step(7'd0, parallel_in[47]);
`endif
        end
      end
      SEND: begin
        busy_n = 1'b1;
        if (cnt == 6'd0) begin
          state_n = DONE;
          fin_n   = 1'b1;
        end else begin
          cnt_n   = cnt - 6'd1;
          shreg_n = {shreg[46:0], 1'b0};
`ifdef CRC7_GEN_EN
          unique case (1'b1)
            (cnt > 6'd8): begin
              nxt_bit = shreg[47];
              crc_n   = crc_step(crc, shreg[47]);
            end
            (cnt > 6'd1 && cnt <= 6'd8): begin
              nxt_bit = crc[6];
              crc_n   = {crc[5:0], 1'b0};
            end
            default: begin
              nxt_bit = 1'b1;
            end
          endcase
`endif
          ser_n = nxt_bit;
          oe_n  = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      serial_out <= 1'b1;
      cmd_oe     <= 1'b0;
      busy       <= 1'b0;
      finished   <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      cnt        <= cnt_n;
      serial_out <= ser_n;
      cmd_oe     <= oe_n;
      busy       <= busy_n;
      finished   <= fin_n;
    end
  end

`ifdef CRC7_GEN_EN
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      crc <= '0;
    end else begin
      crc <= crc_n;
    end
  end
`endif

endmodule

// File: tb/tb_parallel_to_serial.sv
// Scoreboard bench for parallel_to_serial, random and directed frames.
// Honours CRC7_GEN_EN the same way the design does.
module tb_parallel_to_serial;

  logic        CLK;
  logic        RESET_L;
  logic        start_sending;
  logic [47:0] parallel_in;
  logic        serial_out;
  logic        cmd_oe;
  logic        busy;
  logic        finished;

  parallel_to_serial dut (
    .CLK           (CLK),
    .RESET_L       (RESET_L),
    .start_sending (start_sending),
    .parallel_in   (parallel_in),
    .serial_out    (serial_out),
    .cmd_oe        (cmd_oe),
    .busy          (busy),
    .finished      (finished)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [47:0] f;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   b2b_chk  = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [47:0] act,
                     input logic [47:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  // Line frame from the rules: CRC7 as remainder of msg*x^7 mod 0x89
  function automatic logic [47:0] model(input logic [47:0] p);
`ifdef CRC7_GEN_EN
    logic [46:0] v;
    logic [46:0] poly;
    v = {p[47:8], 7'd0};
    for (int i = 46; i >= 7; i--) begin
      poly = 47'h89;
      if (v[i]) v = v ^ (poly << (i - 7));
    end
    return {p[47:8], v[6:0], 1'b1};
`else
    return p;
`endif
  endfunction

  // Monitor: collects each cmd_oe burst and scores it
  int          nb       = 0;
  int          idle_run = 0;
  logic [47:0] bits     = '0;
  exp_t        cur;
  bit          orphan   = 1'b0;

  always @(negedge CLK) begin
    if (!RESET_L) begin
      nb = 0;
      q.delete();
      idle_run = 0;
      chk("reset_serial_out", 48'(serial_out), 48'd1);
      chk("reset_cmd_oe", 48'(cmd_oe), 48'd0);
      chk("reset_finished", 48'(finished), 48'd0);
    end else if (cmd_oe) begin
      if (nb == 0) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          orphan = 1'b1;
          $display("FAIL unexpected_frame: cmd_oe 1 with none pending");
        end else begin
          cur = q.pop_front();
          orphan = 1'b0;
          chk("first_bit_cycle", 48'(cyc), 48'(cur.acc));
        end
        if (b2b_chk) chk("b2b_idle_cycles", 48'(idle_run), 48'd1);
        idle_run = 0;
      end
      bits = {bits[46:0], serial_out};
      nb++;
      chk("finished_during_send", 48'(finished), 48'd0);
    end else begin
      if (nb > 0) begin
        chk("oe_length", 48'(nb), 48'd48);
        if (!orphan) chk("frame", bits, cur.f);
        chk("finished_pulse", 48'(finished), 48'd1);
        chk("done_busy", 48'(busy), 48'd1);
        nb = 0;
      end else begin
        chk("stray_finished", 48'(finished), 48'd0);
      end
      chk("idle_line", 48'(serial_out), 48'd1);
      if (!busy) idle_run++;
    end
  end

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (busy && k < 200);
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: busy 1 after %0d cycles", k);
    end
  endtask

  task automatic send(input logic [47:0] p, input logic [47:0] e);
    logic [63:0] r;
    exp_t x;
    wait_idle();
    start_sending = 1'b1;
    parallel_in   = p;
    @(posedge CLK);
    #1;
    start_sending = 1'b0;
    x.f   = e;
    x.acc = cyc;
    q.push_back(x);
    r = {$urandom(), $urandom()};
    parallel_in = r[47:0];
  endtask

  initial begin
    exp_t        xa;
    exp_t        xb;
    logic [63:0] r;
    logic [47:0] pa;
    logic [47:0] pb;
    int          acc;

    RESET_L       = 1'b0;
    start_sending = 1'b0;
    parallel_in   = '0;
    repeat (3) @(posedge CLK);
    #1;
    RESET_L = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("idle_serial_out", 48'(serial_out), 48'd1);
      chk("idle_cmd_oe", 48'(cmd_oe), 48'd0);
      chk("idle_busy", 48'(busy), 48'd0);
      chk("idle_finished", 48'(finished), 48'd0);
    end

`ifdef CRC7_GEN_EN
    send(48'h400000000000, 48'h400000000095);
    send(48'h510000000000, 48'h510000000055);
    send(48'h4000000000FE, 48'h400000000095);
`else
    send(48'h400000000095, 48'h400000000095);
`endif

    // start pulse and new data while a frame is in flight
    pa = 48'h4A5A5A5A5A00 | 48'h3C;
    send(pa, model(pa));
    repeat (19) @(posedge CLK);
    #1;
    start_sending = 1'b1;
    parallel_in   = 48'hFFFFFFFFFFFF;
    @(posedge CLK);
    #1;
    start_sending = 1'b0;
    wait_idle();
    repeat (8) @(negedge CLK);

    // reset in the middle of a frame
    pa = 48'h7123456789AB;
    send(pa, model(pa));
    repeat (24) @(posedge CLK);
    #2;
    RESET_L = 1'b0;
    #1;
    chk("abort_serial_out", 48'(serial_out), 48'd1);
    chk("abort_cmd_oe", 48'(cmd_oe), 48'd0);
    chk("abort_busy", 48'(busy), 48'd0);
    chk("abort_finished", 48'(finished), 48'd0);
    repeat (2) @(posedge CLK);
    #1;
    RESET_L = 1'b1;
    repeat (5) @(negedge CLK);
    pb = 48'h5F00DEADBEEF;
    send(pb, model(pb));

    // start held high across two frames
    wait_idle();
    r  = {$urandom(), $urandom()};
    pa = r[47:0];
    r  = {$urandom(), $urandom()};
    pb = r[47:0];
    start_sending = 1'b1;
    parallel_in   = pa;
    @(posedge CLK);
    #1;
    acc    = cyc;
    xa.f   = model(pa);
    xa.acc = acc;
    xb.f   = model(pb);
    xb.acc = acc + 50;
    q.push_back(xa);
    q.push_back(xb);
    parallel_in = pb;
    repeat (10) @(posedge CLK);
    b2b_chk = 1'b1;
    do begin
      @(posedge CLK);
      #1;
    end while (cyc < acc + 50);
    start_sending = 1'b0;
    wait_idle();
    b2b_chk = 1'b0;

    for (int i = 0; i < 24; i++) begin
      r  = {$urandom(), $urandom()};
      pa = r[47:0];
      send(pa, model(pa));
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end

    wait_idle();
    repeat (4) @(negedge CLK);
    chk("queue_drained", 48'(q.size()), 48'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
